// File: rtl/expr_pkg.sv
// Shared field map, sizes and state encoding for the expression
// result unpacker and its vector FIFO.
package expr_pkg;

   localparam int NUM_FIELDS = 18;
   localparam int Y_W        = 90;

   localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

   typedef enum logic {IDLE, STREAM} state_e;

   function automatic int fld_w(input int k);
      return 4 + (k % 3);
   endfunction

   // Fields come in groups of three (4+5+6 = 15 bits), y0 at the top.
   function automatic int fld_msb(input int k);
      int off;
      unique case (k % 3)
         0:       off = 0;
         1:       off = 4;
         default: off = 9;
      endcase
      return 89 - 15 * (k / 3) - off;
   endfunction

   function automatic logic fld_sgn(input int k);
      return ((k / 3) % 2) == 1;
   endfunction

endpackage

// File: rtl/expr_fifo2.sv
// Two-entry FIFO holding whole packed result vectors.
// Caller guarantees no push when full and no pop when empty.
module expr_fifo2
   import expr_pkg::*;
#(
   parameter int W = Y_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (pop_i) begin
            rd_q <= ~rd_q;
         end
         unique case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/expr_result_unpacker.sv
// Buffers packed 90-bit result vectors and streams them out one
// extended, tagged field per cycle.
module expr_result_unpacker
   import expr_pkg::*;
#(
   parameter int VID_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Y_W-1:0]   in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_idx,
   output logic [7:0]       out_data,
   output logic             out_signed,
   output logic             out_last,
   output logic [VID_W-1:0] out_vid
);

   logic             push;
   logic             pop;
   logic             hs;
   logic [1:0]       count;
   logic [Y_W-1:0]   head;
   state_e           state_q, state_d;
   logic [4:0]       fidx_q, fidx_d;
   logic [VID_W-1:0] vid_q, vid_d;

   int               dec_k;
   int               dec_w;
   int               dec_lsb;
   logic             dec_sgn;
   logic [Y_W+5:0]   dec_pad;
   logic [5:0]       dec_raw;
   logic [7:0]       dec_ext;

   assign in_ready  = (count < 2'd2);
   assign push      = in_valid && in_ready;
   assign out_valid = (state_q == STREAM);
   assign hs        = out_valid && out_ready;

   expr_fifo2 #(.W(Y_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (in_data),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fidx_q  <= 5'd0;
         vid_q   <= '0;
      end else begin
         state_q <= state_d;
         fidx_q  <= fidx_d;
         vid_q   <= vid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fidx_d  = fidx_q;
      vid_d   = vid_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (push) state_d = STREAM;
         end
         default: begin
            if (hs) begin
               if (fidx_q == LAST_IDX) begin
                  pop    = 1'b1;
                  fidx_d = 5'd0;
                  vid_d  = vid_q + 1'b1;
                  // Only the head remains and nothing new arrives.
                  if (count == 2'd1 && !push) state_d = IDLE;
               end else begin
                  fidx_d = fidx_q + 5'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      dec_k   = int'(fidx_q);
      dec_w   = fld_w(dec_k);
      dec_lsb = fld_msb(dec_k) - dec_w + 1;
      dec_sgn = fld_sgn(dec_k);
      dec_pad = {6'b0, head};
      dec_raw = dec_pad[dec_lsb +: 6];
      dec_ext = 8'd0;
      unique case (1'b1)
         (dec_w == 4):
            dec_ext = dec_sgn ? {{4{dec_raw[3]}}, dec_raw[3:0]}
                              : {4'b0, dec_raw[3:0]};
         (dec_w == 5):
            dec_ext = dec_sgn ? {{3{dec_raw[4]}}, dec_raw[4:0]}
                              : {3'b0, dec_raw[4:0]};
         default:
            dec_ext = dec_sgn ? {{2{dec_raw[5]}}, dec_raw[5:0]}
                              : {2'b0, dec_raw[5:0]};
      endcase
   end

   assign out_idx    = fidx_q;
   assign out_data   = out_valid ? dec_ext : 8'd0;
   assign out_signed = out_valid && dec_sgn;
   assign out_last   = out_valid && (fidx_q == LAST_IDX);
   assign out_vid    = vid_q;

endmodule

// File: doc/expr_result_unpacker.md
# expr_result_unpacker

Receive-side counterpart of the packed 90-bit expression result bus `{y0,…,y17}` produced by the expression blocks. Accepts whole result vectors over a valid/ready handshake and buffers up to two of them. Streams each vector back out one field per cycle as `y0` … `y17`, sign- or zero-extended to 8 bits and tagged with field index and vector ID. Sits between an expression DUT and the checker/trace logic, which compares fields individually.

## Interface
Parameters:
- `VID_W`, 16: width of the vector ID counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  packed vector present.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_data`  in  90  packed `{y0,…,y17}`, `y0` in MSBs.
- `out_valid`  out  1  field on `out_*` is valid.
- `out_ready`  in  1  consumer takes field.
- `out_idx`  out  5  field index, 0..17.
- `out_data`  out  8  field value extended to 8 bits.
- `out_signed`  out  1  field is a signed field.
- `out_last`  out  1  `out_idx == 17`.
- `out_vid`  out  VID_W  vector ID of the current field.

## Operation
Field map for k = 0..17:
- width w = 4 + (k mod 3)
- msb = 89 − 15·(k div 3) − {0,4,9}[k mod 3]
- signed iff (k div 3) is odd, i.e. k ∈ {3,4,5,9,10,11,15,16,17}

Extension:
- Signed fields: sign-extend w bits to 8 bits.
- Unsigned fields: zero-extend w bits to 8 bits.

Buffering:
- 2-entry FIFO of 90-bit vectors.
- `in_ready = (count < 2)`, taken from the registered count. It does not depend on this cycle's pop.
- A push occurs when `in_valid && in_ready`.

States:
- IDLE: FIFO empty, `out_valid = 0`. A push moves to STREAM with field counter `fidx = 0`.
- STREAM: `out_valid = 1`. Outputs are decoded from the FIFO head and `fidx`.
  - Each `out_valid && out_ready` increments `fidx`.
  - On the last field (`fidx = 17`), pop the head, set `fidx = 0`, and increment `vid` (wraps at 2^VID_W).
  - If the FIFO is still non-empty after the pop, stay in STREAM with no bubble; otherwise go to IDLE.
- Push and pop in the same cycle are both performed; count is unchanged.

Reset values: `in_ready = 1`, `out_valid = 0`, `out_idx = 0`, `out_data = 0`, `out_signed = 0`, `out_last = 0`, `out_vid = 0`. FIFO is empty, state is IDLE.

Reset asserted mid-vector discards all buffered data immediately. After release, the first accepted vector has `vid = 0`.

## Timing
- No combinational path from `in_*` to `out_*`.
- Latency: a vector accepted at edge t into an empty FIFO presents field 0 in the cycle after t.
- Throughput: 18 cycles per vector at `out_ready = 1`; back-to-back vectors stream with no idle cycle.
- `out_*` are held stable while `out_valid && !out_ready`.
- `out_data`, `out_signed`, `out_last` are combinational decodes of registered head, `fidx` and `vid`. There is no comb path from `out_ready` to `out_*`.

## Structure
- Package `expr_pkg` holds:
  - `NUM_FIELDS = 18`, `Y_W = 90`
  - field width, msb and signedness functions of k
  - state enum `{IDLE, STREAM}`
- Sub-module `expr_fifo2`: 2-entry, 90-bit FIFO with push/pop/count and async active-low reset.
- Top module holds the FSM, field counter, vid counter and field extraction mux.

## Test plan
- `in_data` = all ones, `out_ready = 1` → 18 fields, idx 0..17. Unsigned fields give 0x0F/0x1F/0x3F by width; signed fields give 0xFF. `out_last` only on idx 17. `vid = 0`.
- `in_data` with only `y3 = 4'b1000` and `y5 = 6'b011111` → idx 3 = 0xF8, idx 5 = 0x1F, all other fields 0x00.
- Three vectors offered back-to-back with `out_ready = 0`:
  - `in_ready` drops after the 2nd accept.
  - Raising `out_ready` streams 36 fields with `vid` 0 then 1, no bubble between them.
  - The 3rd vector is accepted in the cycle after the first vector's field 17 handshake.
- Random `out_ready` toggling → `out_*` stable during every stall; field sequence identical to the unstalled run.
- Assert `rst_n` low at idx 9 of a vector → outputs return to reset values asynchronously. A new vector after release starts at idx 0 with `vid = 0`.
- Stream 2^VID_W + 1 vectors with `VID_W = 4` → `vid` wraps 15 → 0.
